// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder used as the serial datapath
module full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_carry;
  assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_SUB_EN adds i_sub for subtraction
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, sum_q, sum_d;
  logic carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic fa_sum, fa_carry, sub, accept;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = i_sub;
`else
  assign sub = 1'b0;
`endif
  assign accept = i_start && (state_q != ST_RUN);
  full_adder u_fa (
    .i_x    (x_q[0]),
    .i_y    (y_q[0]),
    .i_carry(carry_q),
    .o_sum  (fa_sum),
    .o_carry(fa_carry)
  );
  // Next state: load on accept, shift one bit per RUN cycle, single DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (accept) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      x_d     = i_x;
      y_d     = sub ? ~i_y : i_y;
      sum_d   = '0;
      carry_d = sub ? 1'b1 : i_carry;
    end else if (state_q == ST_RUN) begin
      cnt_d   = cnt_q + 1'b1;
      x_d     = x_q >> 1;
      y_d     = y_q >> 1;
      sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
      carry_d = fa_carry;
      state_d = (cnt_q == CW'(WIDTH - 1)) ? ST_DONE : ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end
  // State and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_carry = carry_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer that computes a WIDTH-bit sum with a single `full_adder` instance, one bit per clock, LSB first. It loads two operands and a carry-in on a start handshake and walks a bit counter through the operands. It holds the carry between cycles in a register and raises a one-cycle done pulse when the result is valid. It sits between the operand source (register file or test harness) and consumers of the sum, trading area for latency.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  reset; one clock, reset asynchronous and active-high.
- i_start  input  1  request to start an addition; sampled on the rising edge.
- i_x  input  WIDTH  operand A; captured when start is accepted.
- i_y  input  WIDTH  operand B; captured when start is accepted.
- i_carry  input  1  carry-in; captured when start is accepted.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse; result valid.
- o_sum  output  WIDTH  result; held until the next accepted start.
- o_carry  output  1  carry-out of bit WIDTH-1; held with o_sum.

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: WIDTH bit-cycles.
  - DONE: one cycle.
- Transitions:
  - IDLE→RUN on i_start.
  - RUN→DONE when bit counter = WIDTH-1 at the edge.
  - DONE→RUN on i_start (back-to-back); otherwise DONE→IDLE.
- Accept: start is accepted only when o_busy=0, i.e. in IDLE or DONE.
  - On accept: shift_x←i_x, shift_y←i_y, carry_q←i_carry, cnt←0, sum_q←0.
  - i_start in RUN is ignored; it is not queued.
- Each RUN edge:
  - `full_adder` is fed shift_x[0], shift_y[0], carry_q.
  - o_sum bit shifts into sum_q MSB, and sum_q shifts right by one.
  - shift_x and shift_y shift right by one.
  - carry_q←o_carry of the adder; cnt increments.
- After WIDTH RUN edges, sum_q holds the full result LSB-aligned; o_sum=sum_q and o_carry=carry_q.
- Arithmetic: o_carry:o_sum = i_x + i_y + i_carry, modulo 2^(WIDTH+1); there is no other overflow signalling.
- cnt width is $clog2(WIDTH); it never wraps in normal operation because RUN exits at WIDTH-1.

## Timing
- Reset values: state=IDLE, o_busy=0, o_done=0, o_sum=0, o_carry=0; cnt and shift registers are 0.
- Reset mid-RUN: the operation is aborted immediately (asynchronous), o_done is not pulsed, and outputs return to the reset values.
- Latency: accept edge E0; o_busy=1 from E0 to E_WIDTH; o_done=1 for exactly the cycle following E_WIDTH.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts (start asserted during DONE).
- Start in DONE: o_done still pulses for that cycle. The next edge reloads the operands; o_sum/o_carry then hold the new partial values and are valid only at the next o_done.
- Operands may change freely after the accept edge.

## Configuration
- SERIAL_ADDER_SUB_EN:
  - Defined: adds input port i_sub (1 bit). When i_sub=1 at accept, shift_y loads ~i_y and carry_q loads 1 (i_carry is ignored), giving o_sum = i_x - i_y and o_carry = 1 when there is no borrow. When i_sub=0, behaviour is identical to the undefined case.
  - Undefined: no i_sub port; addition only.

## Structure
- Shared package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant.
- One sub-module: the existing `full_adder` (ports i_x, i_y, i_carry, o_sum, o_carry), instantiated once.
- The controller owns the FSM, counter, shift registers and carry register.

## Test plan
All scenarios use WIDTH=8.
- Reset, then idle for 5 cycles -> o_busy=0, o_done=0, o_sum=0x00, o_carry=0.
- Start with x=0xFF, y=0x01, c=0 -> o_done 8 cycles after accept; o_sum=0x00, o_carry=1.
- Start with x=0xA5, y=0x5A, c=1 -> o_sum=0x00, o_carry=1. Then idle 3 cycles -> outputs held, o_done low.
- Start x=0x12, y=0x34, c=0 and re-assert i_start with x=0xFF at cycle 3 of RUN -> ignored; o_sum=0x46, o_carry=0.
- Assert i_rst at cycle 4 of RUN -> state IDLE, o_done never pulses, outputs 0. Then a new start x=0x03, y=0x04 -> o_sum=0x07.
- Back-to-back starts (0x10+0x20, then 0x80+0x80 issued in DONE) -> results 0x30/c0 then 0x00/c1, spaced 9 cycles. With SERIAL_ADDER_SUB_EN: x=0x05, y=0x07, i_sub=1 -> o_sum=0xFE, o_carry=0.
